seq_stream_sched: RTL

- Round-robin scheduler and serializer that shares one serial 1101 sequence-detector core between two word sources, A and B.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts each word MSB-first into the core, one bit per clock.
- Reports the match count for each word, plus saturating running totals per source.
- Sits between packet-level producers and the bit-serial Moore detection logic.

---
 rtl/seq_sched_pkg.sv | 22 ++
 rtl/seq_1101_core.sv | 41 ++++
 rtl/seq_stream_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seq_sched_pkg.sv
// Shared types for the two-source 1101 stream scheduler: scheduler states,
// detector core states and source identifiers.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // nothing matched
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "110"
    S4 = 3'd4   // "1101" (match)
  } core_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/seq_1101_core.sv
// Moore overlapping "1101" detector. Advances one bit per enabled clock;
// clr forces the start state. y is high while the core sits in S4.
module seq_1101_core
  import seq_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic y
);

  core_state_t state, nxt;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S0;
    else        state <= nxt;
  end

  // Next-state: clear wins, otherwise step only on enabled cycles.
  always_comb begin
    nxt = state;
    if (clr) begin
      nxt = S0;
    end else if (en) begin
      unique case (state)
        S0:      nxt = din ? S1 : S0;
        S1:      nxt = din ? S2 : S0;
        S2:      nxt = din ? S2 : S3;
        S3:      nxt = din ? S4 : S0;
        S4:      nxt = din ? S2 : S0;
        default: nxt = S0;
      endcase
    end
  end

  assign y = (state == S4);

endmodule

// File: rtl/seq_stream_sched.sv
// Round-robin scheduler sharing one serial 1101 detector between sources A
// and B. Words are shifted MSB-first; per-word match counts are reported with
// done and accumulated into saturating per-source totals.
// Optional feature macro: SEQ_SCHED_CARRY_EN -- when defined, detector state
// carries across consecutive words of the same owner (clear only on owner
// change); when undefined, the detector is cleared on every transfer.
module seq_stream_sched
  import seq_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  input  logic [WIDTH-1:0]       a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [WIDTH-1:0]       b_data,
  output logic                   b_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   done_src,
  output logic [$clog2(WIDTH):0] word_matches,
  output logic [CNT_W-1:0]       total_a,
  output logic [CNT_W-1:0]       total_b
);

  localparam int MW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);
  localparam int SW = ((CNT_W > MW) ? CNT_W : MW) + 1;

  // Add a word count to a total, clamping at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] t,
                                               input logic [MW-1:0]    a);
    logic [SW-1:0] s;
    s = SW'(t) + SW'(a);
    if (s > SW'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    else                        return s[CNT_W-1:0];
  endfunction

  sched_state_t   state, nxt;
  logic           rr;
  logic           owner;
  logic [WIDTH-1:0] word;
  logic [IW-1:0]  idx;
  logic [MW-1:0]  cnt;
  logic           en_d;
  logic           grant_a, grant_b, xfer;
  logic           core_en, core_din, core_clr, core_y, hit;

  // The pointer side wins when it is requesting; otherwise the other side.
  assign grant_a = (rr == SRC_A) ? a_valid : (a_valid && !b_valid);
  assign grant_b = (rr == SRC_B) ? b_valid : (b_valid && !a_valid);
  assign a_ready = (state == ST_IDLE) && grant_a;
  assign b_ready = (state == ST_IDLE) && grant_b;
  assign xfer    = (a_valid && a_ready) || (b_valid && b_ready);
  assign busy    = (state != ST_IDLE);

`ifdef SEQ_SCHED_CARRY_EN
  logic prev_valid, prev_owner;
  // Clear only when the owner changes (or on the first word after reset).
  assign core_clr = xfer && (!prev_valid || (prev_owner != b_ready));
`else
  // Every word starts from a clean detector.
  assign core_clr = xfer;
`endif

  // en_d lines up with the core output that reflects the last shifted bit.
  assign hit          = en_d && core_y;
  assign done_src     = done ? owner : 1'b0;
  assign word_matches = done ? (cnt + MW'(hit)) : '0;

  // Scheduler next-state and per-state core drive.
  always_comb begin
    nxt      = state;
    core_en  = 1'b0;
    core_din = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE:  if (xfer) nxt = ST_SHIFT;
      ST_SHIFT: begin
        core_en  = 1'b1;
        core_din = word[idx];
        if (idx == '0) nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        done = 1'b1;
        nxt  = ST_IDLE;
      end
      default:  nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer, enable delay, totals.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rr      <= SRC_A;
      en_d    <= 1'b0;
      total_a <= '0;
      total_b <= '0;
`ifdef SEQ_SCHED_CARRY_EN
      prev_valid <= 1'b0;
      prev_owner <= SRC_A;
`endif
    end else begin
      state <= nxt;
      en_d  <= core_en;
      if (xfer) begin
        rr <= b_ready ? SRC_A : SRC_B;
`ifdef SEQ_SCHED_CARRY_EN
        prev_valid <= 1'b1;
        prev_owner <= b_ready;
`endif
      end
      if (done) begin
        if (owner == SRC_B) total_b <= sat_add(total_b, word_matches);
        else                total_a <= sat_add(total_a, word_matches);
      end
    end
  end

  // Word datapath: capture on transfer, walk the bit index, count matches.
  always_ff @(posedge clk) begin
    if (xfer) begin
      word  <= b_ready ? b_data : a_data;
      owner <= b_ready;
      idx   <= IW'(WIDTH - 1);
      cnt   <= '0;
    end else begin
      if (state == ST_SHIFT) idx <= idx - 1'b1;
      if (hit)               cnt <= cnt + 1'b1;
    end
  end

  seq_1101_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (core_en),
    .clr   (core_clr),
    .din   (core_din),
    .y     (core_y)
  );

endmodule
